// File: rtl/ro_meas_ctrl.sv
// ---------------------------------------------------------------------------
// ro_meas_ctrl
//
// Measurement controller for the analog inverter ring oscillator. On an
// accepted start it enables the ring, waits WARMUP settling cycles, then
// counts rising edges of the (pre-divided, asynchronous) ring output over a
// gate window of 2^(gate_sel+8) clk cycles and reports the result with a
// one-cycle done pulse. abort cancels a measurement without touching the
// previous result.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   measurement request, accepted only when idle
//   abort     in   cancels a measurement in warm-up or measure
//   gate_sel  in   gate window select, N = 2^(gate_sel+8) cycles
//   ro_in     in   divided ring output, asynchronous to clk
//   ro_en     out  ring enable (warm-up and measure only)
//   busy      out  high during warm-up, measure and done
//   done      out  one-cycle pulse, count/ovf valid
//   count     out  last completed edge count, held until next done
//   ovf       out  last result saturated
// ---------------------------------------------------------------------------
module ro_meas_ctrl #(
  parameter int CNT_W       = 16,
  parameter int WARMUP      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       gate_sel,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [2:0]             gate_q;
  logic [15:0]            cyc_q;
  logic [CNT_W-1:0]       acc_q;
  logic                   sat_q;

  logic                   ro_edge;
  logic [15:0]            gate_last;
  logic                   warmup_last;
  logic [CNT_W-1:0]       acc_inc;
  logic                   sat_inc;

  // Rising edge of the synchronized ring output.
  assign ro_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Last cycle index of the gate window: N-1 = 2^(gate_q+8)-1, obtained by
  // shifting the largest window (32767) down by the unused exponent steps.
  assign gate_last   = 16'h7FFF >> (3'd7 - gate_q);
  assign warmup_last = (cyc_q == 16'(WARMUP - 1));

  // Saturating accumulator update. Once at full scale, any further edge is
  // lost information and raises the sat flag instead of wrapping.
  always_comb begin
    acc_inc = acc_q;
    sat_inc = sat_q;
    if (ro_edge) begin
      if (acc_q == {CNT_W{1'b1}}) begin
        sat_inc = 1'b1;
      end else begin
        acc_inc = acc_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Synchronizer, measurement FSM and registered outputs. The final MEASURE
  // cycle hands acc_inc/sat_inc straight to count/ovf so an edge detected in
  // that last cycle is still included in the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sync_q <= '0;
      prev_q <= 1'b0;
      gate_q <= 3'd0;
      cyc_q  <= 16'd0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
      ro_en  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      done   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state  <= ST_WARMUP;
            gate_q <= gate_sel;
            cyc_q  <= 16'd0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
            ro_en  <= 1'b1;
            busy   <= 1'b1;
          end
        end

        ST_WARMUP: begin
          if (abort) begin
            state <= ST_IDLE;
            ro_en <= 1'b0;
            busy  <= 1'b0;
          end else if (warmup_last) begin
            state <= ST_MEASURE;
            cyc_q <= 16'd0;
          end else begin
            cyc_q <= cyc_q + 16'd1;
          end
        end

        ST_MEASURE: begin
          if (abort) begin
            state <= ST_IDLE;
            ro_en <= 1'b0;
            busy  <= 1'b0;
          end else begin
            acc_q <= acc_inc;
            sat_q <= sat_inc;
            if (cyc_q == gate_last) begin
              state <= ST_DONE;
              count <= acc_inc;
              ovf   <= sat_inc;
              done  <= 1'b1;
              ro_en <= 1'b0;
            end else begin
              cyc_q <= cyc_q + 16'd1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          ro_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ro_meas_ctrl
//
// Scoreboard bench for ro_meas_ctrl. Two instances share all inputs: one
// with the default 16-bit counter and one with an 8-bit counter so that
// saturation is reachable. The stimulus side records every accepted
// measurement in a queue; the monitor side walks that queue every cycle to
// derive expected ro_en/busy/done and, at the done cycle, computes the edge
// count from the recorded ro_in history.
// ---------------------------------------------------------------------------
module tb_ro_meas_ctrl;

  localparam int W  = 16;
  localparam int SS = 2;

  typedef struct {
    int k;
    int n;
  } run_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [2:0]  gate_sel;
  logic        ro_in;

  logic        ro_en;
  logic        busy;
  logic        done;
  logic [15:0] count;
  logic        ovf;
  logic        ro_en8;
  logic        busy8;
  logic        done8;
  logic [7:0]  count8;
  logic        ovf8;

  ro_meas_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gate_sel(gate_sel), .ro_in(ro_in),
    .ro_en(ro_en), .busy(busy), .done(done), .count(count), .ovf(ovf)
  );

  ro_meas_ctrl #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gate_sel(gate_sel), .ro_in(ro_in),
    .ro_en(ro_en8), .busy(busy8), .done(done8), .count(count8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock-edge history: ro_in as seen at each edge (forced low while in
  // reset, since the synchronizer is cleared then) and the reset level.
  int cyc = 0;
  bit hist     [0:131071];
  bit rst_hist [0:131071];

  always @(posedge clk) begin
    hist[cyc]     <= rst ? 1'b0 : ro_in;
    rst_hist[cyc] <= rst;
    cyc           <= cyc + 1;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  run_t exp_q[$];
  int   abort_at[int];
  int   exp_cnt16 = 0;
  int   exp_cnt8  = 0;
  bit   exp_ovf16 = 1'b0;
  bit   exp_ovf8  = 1'b0;

  int   free_edge = 0;
  int   act_k     = -1;
  int   act_done  = -1;

  int   ro_mode  = 0;
  int   ro_half  = 4;
  bit   ro_level = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, cyc - 1, act, exp);
    end
  endtask

  // Reference edge count for a run accepted at edge k with an n-cycle gate.
  // The gate covers the cycles following edges k+W .. k+W+n-1. A rise first
  // sampled at edge m reaches the edge detector SS-1 cycles later, so it
  // counts when m+SS-1 lies inside that range.
  function automatic int countEdges(input int k, input int n);
    int c;
    c = 0;
    for (int m = k + W + 1 - SS; m <= k + W + n - SS; m++)
      if (hist[m] && !hist[m-1]) c++;
    return c;
  endfunction

  // Per-cycle check of every output against the scoreboard queue.
  task automatic monitorCycle();
    int   e;
    int   de;
    int   c;
    run_t f;
    bit   x_en;
    bit   x_busy;
    bit   x_done;
    e      = cyc - 1;
    x_en   = 1'b0;
    x_busy = 1'b0;
    x_done = 1'b0;
    if (rst_hist[e]) begin
      exp_q.delete();
      exp_cnt16 = 0;
      exp_cnt8  = 0;
      exp_ovf16 = 1'b0;
      exp_ovf8  = 1'b0;
    end else if (exp_q.size() > 0) begin
      f  = exp_q[0];
      de = f.k + W + f.n;
      if (abort_at.exists(f.k) && e >= abort_at[f.k]) begin
        void'(exp_q.pop_front());
      end else if (e >= f.k && e < de) begin
        x_en   = 1'b1;
        x_busy = 1'b1;
      end else if (e == de) begin
        x_busy    = 1'b1;
        x_done    = 1'b1;
        c         = countEdges(f.k, f.n);
        exp_cnt16 = (c > 65535) ? 65535 : c;
        exp_ovf16 = (c > 65535);
        exp_cnt8  = (c > 255) ? 255 : c;
        exp_ovf8  = (c > 255);
        void'(exp_q.pop_front());
      end
    end
    checkOutput("ro_en",  {31'd0, ro_en},  {31'd0, x_en});
    checkOutput("busy",   {31'd0, busy},   {31'd0, x_busy});
    checkOutput("done",   {31'd0, done},   {31'd0, x_done});
    checkOutput("count",  {16'd0, count},  exp_cnt16);
    checkOutput("ovf",    {31'd0, ovf},    {31'd0, exp_ovf16});
    checkOutput("ro_en8", {31'd0, ro_en8}, {31'd0, x_en});
    checkOutput("busy8",  {31'd0, busy8},  {31'd0, x_busy});
    checkOutput("done8",  {31'd0, done8},  {31'd0, x_done});
    checkOutput("count8", {24'd0, count8}, exp_cnt8);
    checkOutput("ovf8",   {31'd0, ovf8},   {31'd0, exp_ovf8});
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      monitorCycle();
    end
  end

  // Ring output generator: constant level, square wave with half period
  // ro_half, or random bit per cycle.
  initial begin
    int ph;
    ph    = 0;
    ro_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ro_mode)
        0: ro_in = ro_level;
        1: begin
          ph++;
          if (ph >= ro_half) begin
            ph    = 0;
            ro_in = ~ro_in;
          end
        end
        default: ro_in = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Advance one clock edge and apply the acceptance rules to the inputs
  // that were presented at that edge; accepted runs go into the scoreboard.
  task automatic tick();
    int   e;
    run_t r;
    @(posedge clk);
    #1;
    e = cyc - 1;
    if (rst) begin
      act_done  = -1;
      free_edge = e + 1;
    end else if (abort && act_done >= 0 && e > act_k && e <= act_done) begin
      abort_at[act_k] = e;
      act_done  = -1;
      free_edge = e + 1;
    end else if (start && !abort && e >= free_edge) begin
      r.k = e;
      r.n = 1 << (int'(gate_sel) + 8);
      exp_q.push_back(r);
      act_k     = e;
      act_done  = e + W + r.n;
      free_edge = act_done + 2;
    end
    if (act_done >= 0 && e >= act_done) act_done = -1;
  endtask

  task automatic waitIdle();
    while (cyc < free_edge) tick();
  endtask

  // One measurement: ro_in mode/parameter, gate select, optional abort at
  // edge k+abort_off (0 = none). start is re-pulsed during warm-up, measure
  // and the done cycle; those pulses must all be ignored.
  task automatic applyStimulus(input int gsel, input int mode, input int param, input int abort_off);
    int k;
    int n;
    int stop;
    ro_mode = mode;
    if (mode == 0) ro_level = param[0];
    else           ro_half  = param;
    waitIdle();
    gate_sel = 3'(gsel);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    gate_sel = 3'($urandom_range(7, 0));
    k    = act_k;
    n    = 1 << (gsel + 8);
    stop = k + W + n + 1;
    while (cyc <= stop) begin
      abort = (abort_off > 0) && (cyc == k + abort_off);
      start = (cyc == k + 3) || (cyc == k + W + 50) || (cyc == k + W + n) || (cyc == k + W + n + 1);
      tick();
      if (abort) begin
        abort = 1'b0;
        start = 1'b0;
        break;
      end
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, edge %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gsel;
    int mode;
    int param;
    int aoff;
    int n;

    // Reset held three edges with start high and ro_in toggling randomly;
    // start is still high on the first edge after reset and is accepted.
    rst      = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    gate_sel = 3'd0;
    ro_mode  = 2;
    repeat (3) tick();
    rst     = 1'b0;
    ro_mode = 1;
    ro_half = 4;
    tick();
    start = 1'b0;
    while (cyc <= act_k + W + 256 + 1) tick();
    $display("[TB] reset run done, count=%0d", count);

    // Directed runs.
    applyStimulus(0, 1, 4, 0);        // period 8, gate 256
    applyStimulus(2, 0, 1, 0);        // held high, gate 1024
    applyStimulus(1, 1, 1, 0);        // period 2, gate 512: saturates 8-bit
    applyStimulus(0, 1, 4, 0);        // period 8 again, clears ovf
    applyStimulus(0, 1, 4, W + 100);  // abort in measure
    applyStimulus(1, 1, 3, 5);        // abort in warm-up
    applyStimulus(0, 1, 4, 0);

    // start held high: back-to-back measurements.
    ro_mode = 1;
    ro_half = 4;
    waitIdle();
    gate_sel = 3'd0;
    start    = 1'b1;
    repeat (3 * (W + 256 + 2)) tick();
    start = 1'b0;
    waitIdle();
    $display("[TB] back-to-back runs done");

    // Reset in the middle of a measurement.
    ro_half = 3;
    waitIdle();
    gate_sel = 3'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Randomized runs.
    for (int i = 0; i < 10; i++) begin
      gsel  = $urandom_range(2, 0);
      n     = 1 << (gsel + 8);
      mode  = $urandom_range(2, 0);
      param = (mode == 0) ? int'($urandom_range(1, 0)) : int'($urandom_range(6, 1));
      aoff  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(W + n, 1)) : 0;
      applyStimulus(gsel, mode, param, aoff);
    end

    waitIdle();
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
